seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter N, default 4: operand and result width in bits, N >= 2.
REQ-002 SHALL have parameter STEP, default 1: maximum bit positions shifted per SHIFT cycle, 1 <= STEP <= N.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port a, input, N bits: operand to shift.
REQ-007 SHALL have port b, input, N bits: unsigned shift amount.
REQ-008 SHALL have port mode, input, 3 bits: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 illegal.
REQ-009 SHALL have port c, output, N bits: registered result.
REQ-010 SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-012 SHALL have port zero, output, 1 bit: high when c == 0; valid whenever done is high.
REQ-013 SHALL have port illegal, output, 1 bit: high with done when the captured mode was illegal.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-015 SHALL, in IDLE with start=1, capture a into c plus mode, and load the effective count k into a remaining counter.
REQ-016 SHALL compute k as: SLL/SRL/SRA, k = min(b, N); ROL/ROR, k = b mod N; illegal mode, k = 0.
REQ-017 SHALL transition IDLE -> SHIFT when k > 0, and IDLE -> DONE when k = 0.
REQ-018 SHALL, on each SHIFT cycle, shift c by s = min(STEP, remaining) positions per mode and decrement remaining by s.
REQ-019 SHALL apply per-mode fill: SLL zero-fills LSBs; SRL zero-fills MSBs; SRA replicates c[N-1]; ROL/ROR wrap bits around.
REQ-020 SHALL transition SHIFT -> DONE on the cycle where remaining <= STEP.
REQ-021 SHALL spend exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-022 SHALL assert done exactly ceil(k/STEP)+1 cycles after the clock edge that sampled start.
REQ-023 SHALL ignore start in SHIFT and DONE, with no queuing and no effect on the operation in progress.
REQ-024 SHALL ignore changes on a, b and mode after capture.
REQ-025 SHALL hold c stable from DONE until the next accepted start.
REQ-026 SHALL, on an illegal mode, return c = a with illegal=1 and zero evaluated on c.
REQ-027 SHALL give SLL/SRL results of 0, and an SRA result of all copies of the sign bit, when b >= N.
REQ-028 SHALL have no combinational path from any input to any output.

Reset
REQ-029 SHALL, when rst_n=0, immediately force state=IDLE, c=0, remaining=0, busy=0, done=0, zero=0 and illegal=0, regardless of clk.
REQ-030 SHALL abort any in-flight operation on reset with no done pulse, then accept start on the first rising edge after rst_n deasserts.

Verification (N=4, STEP=1 unless noted)
REQ-031 SHALL pass: SLL, a=0001, b=1 -> done 2 cycles after start, c=0010, zero=0; SLL, a=0011, b=2 -> done after 3 cycles, c=1100.
REQ-032 SHALL pass: SRA, a=1000, b=2 -> c=1110; SRL, a=1000, b=2 -> c=0010; SRL, a=0101, b=9 -> c=0000, zero=1, done after 5 cycles (k=4).
REQ-033 SHALL pass: ROL, a=1001, b=5 -> k=1, c=0011, done after 2 cycles; ROR, a=0001, b=4 -> k=0, c=0001, done after 1 cycle with busy never high.
REQ-034 SHALL pass: b=0, a=0010, SLL -> done 1 cycle after start, c=0010; mode=110 -> c=a, illegal=1 with done.
REQ-035 SHALL pass: STEP=2, SLL, a=0001, b=3 -> 2 SHIFT cycles, done after 3 cycles, c=1000; start pulsed during SHIFT -> ignored, exactly one done.
REQ-036 SHALL pass: rst_n low mid-SHIFT -> c=0 and busy=0 immediately, no done; next start operates normally.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: captures an operand, shifts it STEP positions per cycle
// (SLL/SRL/SRA/ROL/ROR), then pulses done for one cycle with the registered result.
module seq_shifter #(
  parameter int N    = 4,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   mode,
  output logic [N-1:0] c,
  output logic         busy,
  output logic         done,
  output logic         zero,
  output logic         illegal
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0]  N_B    = N[N-1:0];
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  localparam logic [2:0] M_SLL = 3'b000;
  localparam logic [2:0] M_SRL = 3'b001;
  localparam logic [2:0] M_SRA = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  c_q, c_d, sh;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] rem_q, rem_d, k, s;
  logic          zero_q, ill_q, ill_d;

  // Effective count: linear shifts saturate at N, rotates wrap, illegal does nothing.
  always_comb begin
    k = '0;
    case (mode)
      M_SLL, M_SRL, M_SRA: k = (b >= N_B) ? N_C : CW'(b);
      M_ROL, M_ROR:        k = CW'(b % N_B);
      default:             k = '0;
    endcase
  end

  assign s = (rem_q > STEP_C) ? STEP_C : rem_q;

  // Rotates never reach s == N because their count is reduced mod N.
  always_comb begin
    sh = c_q;
    case (mode_q)
      M_SLL:   sh = c_q << s;
      M_SRL:   sh = c_q >> s;
      M_SRA:   sh = $signed(c_q) >>> s;
      M_ROL:   sh = (c_q << s) | (c_q >> (N_C - s));
      M_ROR:   sh = (c_q >> s) | (c_q << (N_C - s));
      default: sh = c_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    ill_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          c_d     = a;
          mode_d  = mode;
          rem_d   = k;
          ill_d   = (mode > M_ROR);
          state_d = (k != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        c_d   = sh;
        rem_d = rem_q - s;
        if (rem_q <= STEP_C) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      zero_q  <= (c_d == '0);
      ill_q   <= ill_d;
    end
  end

  assign c       = c_q;
  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign zero    = zero_q;
  assign illegal = ill_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: one STEP=1 and one STEP=2 instance share stimulus.
module tb_seq_shifter;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [2:0] mode = '0;
  logic [3:0] c1, c2;
  logic       busy1, done1, zero1, ill1, busy2, done2, zero2, ill2;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_shifter #(.N(4), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .mode(mode),
    .c(c1), .busy(busy1), .done(done1), .zero(zero1), .illegal(ill1));

  seq_shifter #(.N(4), .STEP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .mode(mode),
    .c(c2), .busy(busy2), .done(done2), .zero(zero2), .illegal(ill2));

  // Issues one operation, scrambles inputs right after capture, and reports
  // the latency (negedges after the sampling edge) at which done was seen.
  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] im,
                       input bit sel, output int lat, output logic [3:0] oc,
                       output logic oz, output logic oill, output bit bsy_seen);
    lat = -1; oc = 'x; oz = 1'bx; oill = 1'bx; bsy_seen = 1'b0;
    @(negedge clk); a = ia; b = ib; mode = im; start = 1'b1;
    @(negedge clk); start = 1'b0; a = ~ia; b = 4'd0; mode = 3'b111;
    for (int n = 1; n <= 20; n++) begin
      if (sel ? busy2 : busy1) bsy_seen = 1'b1;
      if (sel ? done2 : done1) begin
        lat = n; oc = sel ? c2 : c1; oz = sel ? zero2 : zero1; oill = sel ? ill2 : ill1;
        break;
      end
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({c1, busy1, done1, zero1, ill1} !== 8'h00) begin
      errors++; $display("FAIL reset_state got %b exp 00000000", {c1, busy1, done1, zero1, ill1});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sll();
    int lat; logic [3:0] oc; logic oz, oi; bit bs;
    do_op(4'b0001, 4'd1, 3'b000, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sll1_lat got %0d exp 2", lat); end
    checks++; if (oc !== 4'b0010) begin errors++; $display("FAIL sll1_c got %b exp 0010", oc); end
    checks++; if ({oz, oi} !== 2'b00) begin errors++; $display("FAIL sll1_flags got %b exp 00", {oz, oi}); end
    checks++; if (c1 !== 4'b0010) begin errors++; $display("FAIL sll1_hold got %b exp 0010", c1); end
    do_op(4'b0011, 4'd2, 3'b000, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sll2_lat got %0d exp 3", lat); end
    checks++; if (oc !== 4'b1100) begin errors++; $display("FAIL sll2_c got %b exp 1100", oc); end
  endtask

  task automatic test_right();
    int lat; logic [3:0] oc; logic oz, oi; bit bs;
    do_op(4'b1000, 4'd2, 3'b010, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (oc !== 4'b1110) begin errors++; $display("FAIL sra_c got %b exp 1110", oc); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sra_lat got %0d exp 3", lat); end
    do_op(4'b1000, 4'd2, 3'b001, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (oc !== 4'b0010) begin errors++; $display("FAIL srl_c got %b exp 0010", oc); end
    do_op(4'b0101, 4'd9, 3'b001, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (oc !== 4'b0000) begin errors++; $display("FAIL srl_big_c got %b exp 0000", oc); end
    checks++; if (oz !== 1'b1) begin errors++; $display("FAIL srl_big_zero got %b exp 1", oz); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL srl_big_lat got %0d exp 5", lat); end
    do_op(4'b1010, 4'd7, 3'b010, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (oc !== 4'b1111) begin errors++; $display("FAIL sra_big_c got %b exp 1111", oc); end
  endtask

  task automatic test_rotate();
    int lat; logic [3:0] oc; logic oz, oi; bit bs;
    do_op(4'b1001, 4'd5, 3'b011, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (oc !== 4'b0011) begin errors++; $display("FAIL rol_c got %b exp 0011", oc); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL rol_lat got %0d exp 2", lat); end
    do_op(4'b0001, 4'd4, 3'b100, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (oc !== 4'b0001) begin errors++; $display("FAIL ror_k0_c got %b exp 0001", oc); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL ror_k0_lat got %0d exp 1", lat); end
    checks++; if (bs !== 1'b0) begin errors++; $display("FAIL ror_k0_busy got %b exp 0", bs); end
    do_op(4'b0110, 4'd1, 3'b100, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (oc !== 4'b0011) begin errors++; $display("FAIL ror1_c got %b exp 0011", oc); end
  endtask

  task automatic test_zero_illegal();
    int lat; logic [3:0] oc; logic oz, oi; bit bs;
    do_op(4'b0010, 4'd0, 3'b000, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b0_lat got %0d exp 1", lat); end
    checks++; if (oc !== 4'b0010) begin errors++; $display("FAIL b0_c got %b exp 0010", oc); end
    do_op(4'b1011, 4'd2, 3'b110, 1'b0, lat, oc, oz, oi, bs);
    checks++; if (oc !== 4'b1011) begin errors++; $display("FAIL ill_c got %b exp 1011", oc); end
    checks++; if ({oi, oz} !== 2'b10) begin errors++; $display("FAIL ill_flags got %b exp 10", {oi, oz}); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL ill_lat got %0d exp 1", lat); end
  endtask

  task automatic test_step2();
    int lat, dones, bcyc; logic [3:0] oc; logic oz, oi; bit bs;
    do_op(4'b0001, 4'd3, 3'b000, 1'b1, lat, oc, oz, oi, bs);
    checks++; if (lat !== 3) begin errors++; $display("FAIL step2_lat got %0d exp 3", lat); end
    checks++; if (oc !== 4'b1000) begin errors++; $display("FAIL step2_c got %b exp 1000", oc); end
    dones = 0; bcyc = 0;
    @(negedge clk); a = 4'b0001; b = 4'd3; mode = 3'b000; start = 1'b1;
    @(negedge clk); start = 1'b1; a = 4'b0111; b = 4'd1; mode = 3'b001;
    if (busy2) bcyc++;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (busy2) bcyc++;
      if (done2) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL step2_ignore_dones got %0d exp 1", dones); end
    checks++; if (bcyc !== 2) begin errors++; $display("FAIL step2_shift_cycles got %0d exp 2", bcyc); end
    checks++; if (c2 !== 4'b1000) begin errors++; $display("FAIL step2_ignore_c got %b exp 1000", c2); end
  endtask

  task automatic test_reset_abort();
    int lat, dones; logic [3:0] oc; logic oz, oi; bit bs;
    @(negedge clk); a = 4'b0001; b = 4'd4; mode = 3'b000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %b exp 1", busy1); end
    rst_n = 1'b0; #1;
    checks++; if ({c1, busy1, done1} !== 6'b000000) begin
      errors++; $display("FAIL abort_async got %b exp 000000", {c1, busy1, done1});
    end
    dones = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); if (done1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", dones); end
    rst_n = 1'b1;
    do_op(4'b0001, 4'd1, 3'b000, 1'b0, lat, oc, oz, oi, bs);
    checks++; if ({lat == 2, oc} !== 5'b10010) begin
      errors++; $display("FAIL abort_recover got lat %0d c %b exp lat 2 c 0010", lat, oc);
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_right();
    test_rotate();
    test_zero_illegal();
    test_step2();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
